// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       OPCODE;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, OPCODE, OP1, OP2, out_ready,
        input  in_ready, out_valid, result, result_hi, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, OPCODE, OP1, OP2, out_ready,
        output in_ready, out_valid, result, result_hi, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU, single-cycle ops plus multi-cycle shift-add MUL
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    alu_pipe_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_z, r_n, r_c, r_v;

    logic               w_accept;
    logic               w_is_mul;
    logic [SW-1:0]      w_sh;
    logic [WIDTH:0]     w_wide;
    logic [WIDTH-1:0]   w_lo;
    logic               w_c, w_v;

    assign bus.in_ready = rstn && ((r_state == S_IDLE) || (r_state == S_HOLD && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_mul     = MUL_EN && (bus.OPCODE == 3'b111);
    assign w_sh         = bus.OP2[SW-1:0];

    // Shifts run one bit wider so the last bit shifted out lands in w_wide's spare bit.
    always_comb begin
        w_wide = '0;
        w_lo   = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (bus.OPCODE)
            3'b000: begin
                w_wide = {1'b0, bus.OP1} + {1'b0, bus.OP2};
                w_lo   = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (bus.OP1[WIDTH-1] == bus.OP2[WIDTH-1]) && (w_lo[WIDTH-1] != bus.OP1[WIDTH-1]);
            end
            3'b001: begin
                w_wide = {1'b0, bus.OP1} - {1'b0, bus.OP2};
                w_lo   = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (bus.OP1[WIDTH-1] != bus.OP2[WIDTH-1]) && (w_lo[WIDTH-1] != bus.OP1[WIDTH-1]);
            end
            3'b010: w_lo = bus.OP1 & bus.OP2;
            3'b011: w_lo = bus.OP1 | bus.OP2;
            3'b100: w_lo = bus.OP1 ^ bus.OP2;
            3'b101: begin
                w_wide = {1'b0, bus.OP1} << w_sh;
                w_lo   = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
            end
            3'b110: begin
                w_wide = {bus.OP1, 1'b0} >> w_sh;
                w_lo   = w_wide[WIDTH:1];
                w_c    = w_wide[0];
            end
            default: begin
                w_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept && w_is_mul) begin
                        r_state  <= S_MUL;
                        r_mcand  <= {{WIDTH{1'b0}}, bus.OP1};
                        r_mplier <= bus.OP2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (w_accept) begin
                        r_state     <= S_HOLD;
                        r_result    <= w_lo;
                        r_result_hi <= '0;
                        r_z         <= (w_lo == '0);
                        r_n         <= w_lo[WIDTH-1];
                        r_c         <= w_c;
                        r_v         <= w_v;
                    end else if (r_state == S_HOLD && bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    // The extra cycle after the last step moves the accumulator into the result registers.
                    if (r_cnt == CW'(WIDTH)) begin
                        r_state     <= S_HOLD;
                        r_result    <= r_acc[WIDTH-1:0];
                        r_result_hi <= r_acc[2*WIDTH-1:WIDTH];
                        r_z         <= (r_acc == '0);
                        r_n         <= r_acc[WIDTH-1];
                        r_c         <= |r_acc[2*WIDTH-1:WIDTH];
                        r_v         <= 1'b0;
                    end else begin
                        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.flag_z    = r_z;
    assign bus.flag_n    = r_n;
    assign bus.flag_c    = r_c;
    assign bus.flag_v    = r_v;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH 8 (MUL) and 16 (no MUL)
module tb_alu_pipe;
    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z, n, c, v;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   w;

    alu_pipe_if #(.WIDTH(8))  i8();
    alu_pipe_if #(.WIDTH(16)) i16();

    alu_pipe #(.WIDTH(8),  .MUL_EN(1'b1)) u_w8  (.clk(clk), .rstn(rstn), .bus(i8.slave));
    alu_pipe #(.WIDTH(16), .MUL_EN(1'b0)) u_w16 (.clk(clk), .rstn(rstn), .bus(i16.slave));

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] lo, input logic [15:0] hi,
                                input logic z, input logic n, input logic c, input logic v);
        return {lo, hi, z, n, c, v};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic issue(input bit w16, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e, output int waits);
        logic ok;
        if (w16) begin
            i16.in_valid = 1'b1; i16.OPCODE = op; i16.OP1 = a; i16.OP2 = b;
        end else begin
            i8.in_valid = 1'b1; i8.OPCODE = op; i8.OP1 = a[7:0]; i8.OP2 = b[7:0];
        end
        waits = 0;
        ok = 1'b0;
        while (!ok && waits < 40) begin
            @(negedge clk);
            ok = w16 ? i16.in_ready : i8.in_ready;
            if (!ok) waits++;
        end
        chk("accept", {35'd0, ok}, 36'd1);
        if (ok) begin
            if (w16) q16.push_back(e); else q8.push_back(e);
        end
        @(posedge clk);
        #1;
        if (w16) i16.in_valid = 1'b0; else i8.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (i8.out_valid && i8.out_ready) begin
            chk("w8_result_expected", {35'd0, q8.size() > 0}, 36'd1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                chk("w8_result", {8'h00, i8.result, 8'h00, i8.result_hi,
                                  i8.flag_z, i8.flag_n, i8.flag_c, i8.flag_v}, e8);
            end
        end
    end

    always @(negedge clk) begin
        if (i16.out_valid && i16.out_ready) begin
            chk("w16_result_expected", {35'd0, q16.size() > 0}, 36'd1);
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                chk("w16_result", {i16.result, i16.result_hi,
                                   i16.flag_z, i16.flag_n, i16.flag_c, i16.flag_v}, e16);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        i8.in_valid = 1'b0;  i8.OPCODE = 3'd0;  i8.OP1 = '0;  i8.OP2 = '0;  i8.out_ready = 1'b1;
        i16.in_valid = 1'b0; i16.OPCODE = 3'd0; i16.OP1 = '0; i16.OP2 = '0; i16.out_ready = 1'b1;

        #12;
        chk("reset_w8", {i8.in_ready, i8.out_valid, i8.result, i8.result_hi,
                         i8.flag_z, i8.flag_n, i8.flag_c, i8.flag_v}, 36'd0);
        chk("reset_w16", {i16.in_ready, i16.out_valid, i16.result,
                          i16.flag_z, i16.flag_n, i16.flag_c, i16.flag_v}, 36'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        issue(0, 3'b000, 16'h7F, 16'h01, mk(16'h80, 0, 0, 1, 0, 1), w);
        chk("add_latency1", {35'd0, i8.out_valid}, 36'd1);
        issue(0, 3'b001, 16'h00, 16'h01, mk(16'hFF, 0, 0, 1, 1, 0), w);
        issue(0, 3'b000, 16'hFF, 16'h01, mk(16'h00, 0, 1, 0, 1, 0), w);

        issue(0, 3'b111, 16'h10, 16'h10, mk(16'h00, 16'h01, 0, 0, 1, 0), w);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("mul_busy", {34'd0, i8.out_valid, i8.in_ready}, 36'd0);
        end
        @(negedge clk);
        chk("mul_latency", {35'd0, i8.out_valid}, 36'd1);
        @(posedge clk); #1;

        i8.out_ready = 1'b0;
        issue(0, 3'b100, 16'hA5, 16'h0F, mk(16'hAA, 0, 0, 1, 0, 0), w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_stable", {26'd0, i8.out_valid, i8.in_ready, i8.result}, {26'd0, 2'b10, 8'hAA});
        end
        @(posedge clk); #1;
        i8.out_ready = 1'b1;
        issue(0, 3'b000, 16'h01, 16'h02, mk(16'h03, 0, 0, 0, 0, 0), w);
        chk("stream_wait0", 36'(w), 36'd0);
        issue(0, 3'b000, 16'h80, 16'h80, mk(16'h00, 0, 1, 0, 1, 1), w);
        chk("stream_wait1", 36'(w), 36'd0);
        issue(0, 3'b000, 16'h7F, 16'h7F, mk(16'hFE, 0, 0, 1, 0, 1), w);
        chk("stream_wait2", 36'(w), 36'd0);
        issue(0, 3'b000, 16'hC0, 16'h50, mk(16'h10, 0, 0, 0, 1, 0), w);
        chk("stream_wait3", 36'(w), 36'd0);

        issue(0, 3'b010, 16'hF0, 16'h3C, mk(16'h30, 0, 0, 0, 0, 0), w);
        issue(0, 3'b011, 16'h0F, 16'hF0, mk(16'hFF, 0, 0, 1, 0, 0), w);
        issue(0, 3'b001, 16'h05, 16'h03, mk(16'h02, 0, 0, 0, 0, 0), w);
        issue(0, 3'b001, 16'h80, 16'h01, mk(16'h7F, 0, 0, 0, 0, 1), w);
        issue(0, 3'b101, 16'h81, 16'h01, mk(16'h02, 0, 0, 0, 1, 0), w);
        issue(0, 3'b110, 16'h81, 16'h01, mk(16'h40, 0, 0, 0, 1, 0), w);
        issue(0, 3'b110, 16'h81, 16'h00, mk(16'h81, 0, 0, 1, 0, 0), w);

        // Reset lands in the middle of this MUL, so its queued result must never appear.
        issue(0, 3'b111, 16'h03, 16'h05, mk(16'h0F, 0, 0, 0, 0, 0), w);
        void'(q8.pop_back());
        repeat (4) @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("midmul_reset", {i8.in_ready, i8.out_valid, i8.result, i8.result_hi,
                             i8.flag_z, i8.flag_n, i8.flag_c, i8.flag_v}, 36'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        issue(0, 3'b000, 16'h03, 16'h04, mk(16'h07, 0, 0, 0, 0, 0), w);

        issue(1, 3'b000, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 0, 1, 0, 1), w);
        chk("w16_add_latency", {35'd0, i16.out_valid}, 36'd1);
        issue(1, 3'b111, 16'h1234, 16'h5678, mk(16'h0000, 0, 1, 0, 0, 0), w);
        chk("w16_mul_off_latency", {35'd0, i16.out_valid}, 36'd1);
        issue(1, 3'b001, 16'h0000, 16'h0001, mk(16'hFFFF, 0, 0, 1, 1, 0), w);

        repeat (3) @(posedge clk);
        #1;
        chk("w8_queue_drained", 36'(q8.size()), 36'd0);
        chk("w16_queue_drained", 36'(q16.size()), 36'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
